// File: rtl/stripe_pkg.sv
// Shared definitions for the byte striper.
//   STRIPE_DATA_W : default byte/lane width
//   LANE0/LANE1   : lane select encodings (value of sel)
//   phase_t       : clk_f phase within a two-cycle window
package stripe_pkg;

  localparam int unsigned STRIPE_DATA_W = 8;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // PH_CAPTURE: first cycle of a window, bytes go into the hold registers.
  // PH_UPDATE : second cycle, its closing edge loads the lane outputs.
  typedef enum logic {
    PH_CAPTURE = 1'b0,
    PH_UPDATE  = 1'b1
  } phase_t;

endpackage

// File: rtl/stripe_lane_reg.sv
// One striping lane: a hold register for a byte captured in the capture
// phase, plus the registered lane output loaded at the window-closing edge.
// Ports:
//   clk_2f, reset : clock, synchronous active-high reset
//   data_in       : input byte
//   valid_in      : input byte valid
//   sel           : lane chosen for the byte presented this cycle
//   update        : high in the cycle whose closing edge updates the lane
//   data_stripe   : lane byte (holds when not valid)
//   valid_stripe  : lane valid
module stripe_lane_reg
  import stripe_pkg::*;
#(
  parameter int unsigned DATA_W = STRIPE_DATA_W,
  parameter logic        LANE   = LANE0
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              sel,
  input  logic              update,
  output logic [DATA_W-1:0] data_stripe,
  output logic              valid_stripe
);

  logic [DATA_W-1:0] hold;
  logic              hold_valid;
  logic              hit;
  logic [DATA_W-1:0] next_data;
  logic              next_valid;

  // A byte arriving in the update cycle bypasses the hold register.
  always_comb begin
    hit        = valid_in && (sel == LANE);
    next_data  = hit ? data_in : hold;
    next_valid = hit | hold_valid;
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      hold         <= '0;
      hold_valid   <= 1'b0;
      data_stripe  <= '0;
      valid_stripe <= 1'b0;
    end else if (update) begin
      if (next_valid) data_stripe <= next_data;
      valid_stripe <= next_valid;
      hold_valid   <= 1'b0;
    end else if (hit) begin
      // sel alternates, so a lane never sees two bytes in one window.
      assert (!hold_valid);
      hold       <= data_in;
      hold_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/byte_striping_2f.sv
// Transmit-side byte striper: one input byte stream (max one byte per cycle)
// is split alternately onto lane 0 and lane 1; lanes update once per
// two-cycle window.
// Ports:
//   clk_2f          : clock
//   reset           : synchronous active-high reset
//   data_in         : input byte
//   valid_in        : input byte valid (always accepted)
//   data_stripe_0/1 : lane bytes, registered
//   valid_stripe_0/1: lane valids, registered
//   stripe_tick     : high in the cycle whose closing edge updates the lanes
module byte_striping_2f
  import stripe_pkg::*;
#(
  parameter int unsigned DATA_W = STRIPE_DATA_W
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_stripe_0,
  output logic              valid_stripe_0,
  output logic [DATA_W-1:0] data_stripe_1,
  output logic              valid_stripe_1,
  output logic              stripe_tick
);

  phase_t phase, phase_next;
  logic   sel;
  logic   idle;   // capture cycle of the current window had no valid byte

  always_ff @(posedge clk_2f) begin
    if (reset) phase <= PH_CAPTURE;
    else       phase <= phase_next;
  end

  always_comb begin
    phase_next = PH_CAPTURE;
    if (phase == PH_CAPTURE) phase_next = PH_UPDATE;
  end

  assign stripe_tick = (phase == PH_UPDATE);

  // Fully idle window resyncs sel so every burst starts on lane 0.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      sel  <= LANE0;
      idle <= 1'b0;
    end else begin
      idle <= (phase == PH_CAPTURE) && !valid_in;
      if (valid_in)                       sel <= ~sel;
      else if (phase == PH_UPDATE && idle) sel <= LANE0;
    end
  end

  stripe_lane_reg #(.DATA_W(DATA_W), .LANE(LANE0)) u_lane0 (
    .clk_2f       (clk_2f),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .sel          (sel),
    .update       (stripe_tick),
    .data_stripe  (data_stripe_0),
    .valid_stripe (valid_stripe_0)
  );

  stripe_lane_reg #(.DATA_W(DATA_W), .LANE(LANE1)) u_lane1 (
    .clk_2f       (clk_2f),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .sel          (sel),
    .update       (stripe_tick),
    .data_stripe  (data_stripe_1),
    .valid_stripe (valid_stripe_1)
  );

endmodule

// File: tb/tb_byte_striping_2f.sv
// Self-checking bench for byte_striping_2f: directed scenarios plus random
// traffic, all compared each cycle against a window-level reference model.
module tb_byte_striping_2f;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] data_stripe_0, data_stripe_1;
  logic       valid_stripe_0, valid_stripe_1, stripe_tick;

  byte_striping_2f #(.DATA_W(8)) dut (
    .clk_2f         (clk_2f),
    .reset          (reset),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .data_stripe_0  (data_stripe_0),
    .valid_stripe_0 (valid_stripe_0),
    .data_stripe_1  (data_stripe_1),
    .valid_stripe_1 (valid_stripe_1),
    .stripe_tick    (stripe_tick)
  );

  always #5 clk_2f = ~clk_2f;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes are gathered per two-cycle window and dealt
  // alternately to lanes; an empty window restarts dealing at lane 0.
  int         mphase   = 0;
  int         nxt_lane = 0;
  logic [7:0] win[$];
  logic [7:0] ed0, ed1;
  logic       ev0, ev1, etick;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    valid_in = v;
    data_in  = d;
    reset    = r;
    @(posedge clk_2f);
    if (r) begin
      ed0 = '0; ed1 = '0; ev0 = 1'b0; ev1 = 1'b0;
      mphase = 0; nxt_lane = 0;
      win.delete();
    end else begin
      if (v) win.push_back(d);
      if (mphase == 1) begin
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (win.size() == 0) nxt_lane = 0;
        foreach (win[i]) begin
          if (nxt_lane == 0) begin ed0 = win[i]; ev0 = 1'b1; end
          else               begin ed1 = win[i]; ev1 = 1'b1; end
          nxt_lane ^= 1;
        end
        win.delete();
      end
      mphase ^= 1;
    end
    etick = (mphase == 1);
    #1;
    chk("tick",   {7'b0, stripe_tick},    {7'b0, etick});
    chk("data0",  data_stripe_0,          ed0);
    chk("valid0", {7'b0, valid_stripe_0}, {7'b0, ev0});
    chk("data1",  data_stripe_1,          ed1);
    chk("valid1", {7'b0, valid_stripe_1}, {7'b0, ev1});
  endtask

  task automatic align0();
    while (mphase != 0) cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    // 1: reset held with traffic present, then tick toggles
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'hAA, 1'b1);
      chk("rst_zero", {data_stripe_0 | data_stripe_1}, 8'h00);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);

    // 2: continuous burst starting in a capture cycle
    align0();
    cycle(1'b0, 8'h00, 1'b0); cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h01, 1'b0); cycle(1'b1, 8'h02, 1'b0);
    chk("b_w1_l0", data_stripe_0, 8'h01);
    chk("b_w1_l1", data_stripe_1, 8'h02);
    cycle(1'b1, 8'h03, 1'b0); cycle(1'b1, 8'h04, 1'b0);
    chk("b_w2_l0", data_stripe_0, 8'h03);
    chk("b_w2_l1", data_stripe_1, 8'h04);

    // 3: odd burst then idle
    cycle(1'b0, 8'h00, 1'b0); cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h10, 1'b0); cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h12, 1'b0); cycle(1'b0, 8'h00, 1'b0);
    chk("odd_l0",  data_stripe_0, 8'h12);
    chk("odd_v1",  {7'b0, valid_stripe_1}, 8'h00);
    cycle(1'b0, 8'h00, 1'b0); cycle(1'b0, 8'h00, 1'b0);
    chk("odd_hold", data_stripe_1, 8'h11);

    // 4: lone byte in update cycle, idle window, then resync to lane 0
    cycle(1'b0, 8'h00, 1'b0); cycle(1'b1, 8'h55, 1'b0);
    chk("lone_l0", data_stripe_0, 8'h55);
    cycle(1'b0, 8'h00, 1'b0); cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h66, 1'b0); cycle(1'b0, 8'h00, 1'b0);
    chk("resync_l0", data_stripe_0, 8'h66);
    chk("resync_v1", {7'b0, valid_stripe_1}, 8'h00);

    // 5: reset after a byte was captured in hold
    align0();
    cycle(1'b1, 8'h20, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0); cycle(1'b0, 8'h00, 1'b0);
    chk("rst_drop", data_stripe_0, 8'h00);
    cycle(1'b1, 8'h21, 1'b0); cycle(1'b0, 8'h00, 1'b0);
    chk("rst_first", data_stripe_0, 8'h21);

    // 6: random traffic with varying density
    for (int i = 0; i < 1000; i++) begin
      logic v;
      v = ($urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 80 : 30));
      cycle(v, 8'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
